gate_truth_checker: RTL and testbench

//   Synthesizable exhaustive checker for small combinational gates (OR, AND, XOR, ...).
//   On start it drives every input vector into the attached gate and samples the gate output.
//   It compares each sample against a parameterised truth table and reports a pass/fail summary.

---
 rtl/gate_truth_checker.sv | 118 +++++++++++
 tb/tb_gate_truth_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// ============================================================================
// gate_truth_checker : sweeps every input vector of a small gate and checks
//                      each sampled output against a truth table.
// Revision 1.0
// ============================================================================
`default_nettype none

module gate_truth_checker #(
  parameter int                   N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b1110,
  parameter int                   SETTLE = 1,
  parameter int                   ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_vec
);

  localparam logic [N_IN-1:0]  LAST_VEC  = {N_IN{1'b1}};
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_IN-1:0]  vec_q;
  logic [3:0]       settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic             fev_q;
  logic [N_IN-1:0]  fevec_q;

  logic             mismatch;
  logic             accept;
  logic [ERR_W-1:0] err_d;

  assign mismatch = (dut_out != TRUTH[vec_q]);
  // A new sweep may only be launched from IDLE or from the single DONE cycle.
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign err_d    = (mismatch && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fev_q    <= 1'b0;
      fevec_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q  <= S_DRIVE;
        vec_q    <= '0;
        settle_q <= SETTLE_LD;
        err_q    <= '0;
        fev_q    <= 1'b0;
        pass_q   <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          S_DRIVE: begin
            if (settle_q != 4'd0) begin
              settle_q <= settle_q - 4'd1;
            end else begin
              // Closing edge of this vector's hold window: sample and judge.
              err_q <= err_d;
              if (mismatch && !fev_q) begin
                fev_q   <= 1'b1;
                fevec_q <= vec_q;
              end
              if (vec_q == LAST_VEC) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                pass_q  <= (err_d == '0);
              end else begin
                vec_q    <= vec_q + 1'b1;
                settle_q <= SETTLE_LD;
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_IDLE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dut_in          = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fevec_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
// ============================================================================
// tb_gate_truth_checker : directed bench for gate_truth_checker with an
//                         arithmetic reference model and per-cycle compare.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_gate_truth_checker;

  localparam int SET = 1;
  localparam int P   = SET + 1;
  localparam int NV  = 4;
  localparam int L   = NV * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic and_mode = 1'b0;
  logic s0_start = 1'b0;
  logic e1_start = 1'b0;

  always #5 clk = ~clk;

  // Main instance: defaults, gate is OR or AND depending on and_mode.
  logic [1:0] dut_in;
  logic       busy, done, pass, fev;
  logic [7:0] err_count;
  logic [1:0] fevec;
  logic       g_out;
  assign g_out = and_mode ? (&dut_in) : (|dut_in);

  gate_truth_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(g_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(fev), .first_err_vec(fevec)
  );

  // SETTLE=0 instance with the gate output stuck at 1.
  logic [1:0] s0_in, s0_fevec;
  logic       s0_busy, s0_done, s0_pass, s0_fev;
  logic [7:0] s0_err;
  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1110), .SETTLE(0), .ERR_W(8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(s0_start), .dut_in(s0_in), .dut_out(1'b1),
    .busy(s0_busy), .done(s0_done), .pass(s0_pass), .err_count(s0_err),
    .first_err_valid(s0_fev), .first_err_vec(s0_fevec)
  );

  // ERR_W=1 instance with the gate output stuck at 0.
  logic [1:0] e1_in, e1_fevec;
  logic       e1_busy, e1_done, e1_pass, e1_fev;
  logic [0:0] e1_err;
  gate_truth_checker #(.N_IN(2), .TRUTH(4'b1110), .SETTLE(1), .ERR_W(1)) u_e1 (
    .clk(clk), .rst_n(rst_n), .start(e1_start), .dut_in(e1_in), .dut_out(1'b0),
    .busy(e1_busy), .done(e1_done), .pass(e1_pass), .err_count(e1_err),
    .first_err_valid(e1_fev), .first_err_vec(e1_fevec)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference gate the checker is configured for: OR.
  function automatic logic ref_gate(input logic [1:0] v);
    return (v != 2'd0);
  endfunction

  // Model: count edges since the sweep was accepted; every P-th edge judges
  // the vector on the wires, the L-th edge ends the sweep.
  bit         m_active;
  int         m_c;
  logic [1:0] m_din, m_fevec;
  logic       m_busy, m_done, m_pass, m_fev;
  logic [7:0] m_err;
  logic       m_mis;
  logic [7:0] m_err_nx;

  assign m_mis    = m_active && (((m_c + 1) % P) == 0) && (g_out != ref_gate(m_din));
  assign m_err_nx = (m_mis && m_err != 8'd255) ? m_err + 8'd1 : m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_c <= 0; m_din <= 2'd0; m_fevec <= 2'd0;
      m_busy <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_fev <= 1'b0; m_err <= 8'd0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        m_err <= m_err_nx;
        if (m_mis && !m_fev) begin
          m_fev   <= 1'b1;
          m_fevec <= m_din;
        end
        if (m_c + 1 == L) begin
          m_active <= 1'b0;
          m_c      <= 0;
          m_done   <= 1'b1;
          m_busy   <= 1'b0;
          m_pass   <= (m_err_nx == 8'd0);
        end else begin
          m_c   <= m_c + 1;
          m_din <= 2'((m_c + 1) / P);
        end
      end else if (start) begin
        m_active <= 1'b1;
        m_c      <= 0;
        m_din    <= 2'd0;
        m_err    <= 8'd0;
        m_fev    <= 1'b0;
        m_pass   <= 1'b0;
        m_busy   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("dut_in", dut_in, m_din);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("pass", pass, m_pass);
      check("err_count", err_count, m_err);
      check("first_err_valid", fev, m_fev);
      check("first_err_vec", fevec, m_fevec);
    end
  end

  // Launch a main sweep; returns cycles from the accepting edge to done.
  task automatic sweep_main(input bit hold_start, output int j);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    j = 0;
    while (!done && j < 200) begin
      if (j < L) check("seq_dut_in", dut_in, 32'(j / P));
      @(negedge clk);
      j++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    int j;
    int dcount;

    repeat (2) @(negedge clk);
    check("rst_dut_in", dut_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_fev", fev, 0);
    check("rst_fevec", fevec, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // OR gate against OR table: clean sweep.
    sweep_main(1'b0, j);
    check("t1_latency", j, 8);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_fev", fev, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // AND gate against OR table: vectors 1 and 2 disagree.
    and_mode = 1'b1;
    sweep_main(1'b0, j);
    check("t2_latency", j, 8);
    check("t2_err", err_count, 2);
    check("t2_fevec", fevec, 1);
    check("t2_fev", fev, 1);
    check("t2_pass", pass, 0);
    @(negedge clk);
    check("t2_done_pulse", done, 0);
    check("t2_err_held", err_count, 2);
    check("t2_dut_in_held", dut_in, 3);
    and_mode = 1'b0;

    // Output stuck at 1, no settle cycles.
    @(negedge clk);
    s0_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s0_start = 1'b0;
    j = 0;
    while (!s0_done && j < 50) begin
      @(negedge clk);
      j++;
    end
    check("t3_latency", j, 4);
    check("t3_err", s0_err, 1);
    check("t3_fevec", s0_fevec, 0);
    check("t3_fev", s0_fev, 1);
    check("t3_pass", s0_pass, 0);
    check("t3_busy", s0_busy, 0);

    // Output stuck at 0, one-bit error counter saturates.
    @(negedge clk);
    e1_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    e1_start = 1'b0;
    j = 0;
    while (!e1_done && j < 50) begin
      @(negedge clk);
      j++;
    end
    check("t4_latency", j, 8);
    check("t4_err", e1_err, 1);
    check("t4_fevec", e1_fevec, 1);
    check("t4_fev", e1_fev, 1);
    check("t4_pass", e1_pass, 0);
    check("t4_dut_in", e1_in, 3);

    // Reset in the middle of vector 2.
    and_mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_at_vec2", dut_in, 2);
    check("t5_err_pre", err_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_dut_in", dut_in, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_err", err_count, 0);
    check("t5_rst_fev", fev, 0);
    check("t5_rst_fevec", fevec, 0);
    check("t5_rst_pass", pass, 0);
    and_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t5_no_done", dcount, 0);
    check("t5_idle_busy", busy, 0);
    sweep_main(1'b0, j);
    check("t5_latency", j, 8);
    check("t5_pass", pass, 1);
    check("t5_err", err_count, 0);

    // start held high: ignored while busy, relaunches from the DONE cycle.
    and_mode = 1'b1;
    sweep_main(1'b1, j);
    check("t6_latency", j, 8);
    check("t6_err", err_count, 2);
    and_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("t6_rebusy", busy, 1);
    check("t6_err_clr", err_count, 0);
    check("t6_fev_clr", fev, 0);
    check("t6_dut_in", dut_in, 0);
    check("t6_pass_clr", pass, 0);
    j = 0;
    while (!done && j < 200) begin
      @(negedge clk);
      j++;
    end
    check("t6_latency2", j, 8);
    check("t6_pass2", pass, 1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
